// File: rtl/wb_sram_target.sv
// wb_sram_target: Wishbone B4 responder with an internal word-addressed SRAM,
// programmable wait states, ERR on out-of-window access and CTI/BTE bursts.
module wb_sram_target #(
    parameter int                       WB_ADDR_WIDTH = 32,
    parameter int                       WB_DATA_WIDTH = 32,
    parameter int                       MEM_ADDR_BITS = 10,
    parameter logic [WB_ADDR_WIDTH-1:0] BASE_ADDR     = '0,
    parameter int                       WAIT_STATES   = 0
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic [WB_ADDR_WIDTH-1:0]   i_adr,
    input  logic [2:0]                 i_cti,
    input  logic [1:0]                 i_bte,
    input  logic [WB_DATA_WIDTH-1:0]   i_dat_w,
    input  logic                       i_cyc,
    input  logic [WB_DATA_WIDTH/8-1:0] i_sel,
    input  logic                       i_stb,
    input  logic                       i_we,
    output logic [WB_DATA_WIDTH-1:0]   o_dat_r,
    output logic                       o_ack,
    output logic                       o_err
);
    localparam int NB = WB_DATA_WIDTH / 8;
    localparam int OB = $clog2(NB);
    localparam int MA = MEM_ADDR_BITS;
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_BURST} state_t;
    state_t                   r_state;
    logic [2:0]               r_cnt;
    logic [MA-1:0]            r_baddr;
    logic                     r_ack, r_err;
    logic [WB_DATA_WIDTH-1:0] r_dat_r;
    logic [WB_DATA_WIDTH-1:0] r_mem [0:(1<<MA)-1];
    logic [WB_ADDR_WIDTH-1:0] w_off, w_idx;
    logic                     w_in_range, w_req, w_start, w_next_ok, w_wr;
    logic [MA:0]              w_inc;
    logic [MA-1:0]            w_mask, w_next, w_waddr, w_raddr;
    logic [WB_DATA_WIDTH-1:0] w_wdata, w_rdata;

    assign w_off      = i_adr - BASE_ADDR;
    assign w_idx      = w_off >> OB;
    assign w_in_range = (i_adr >= BASE_ADDR) && ((w_idx >> MA) == '0);
    assign w_req      = i_cyc & i_stb;
    assign o_ack      = r_ack & w_req;
    assign o_err      = r_err & w_req;
    assign o_dat_r    = r_dat_r;

    // Wrapping bursts keep the upper address bits and roll the low ones.
    assign w_inc      = {1'b0, r_baddr} + (MA+1)'(1);
    assign w_mask     = i_bte == 2'd1 ? MA'(3) : i_bte == 2'd2 ? MA'(7) : i_bte == 2'd3 ? MA'(15) : '0;
    assign w_next     = i_bte == 2'd0 ? w_inc[MA-1:0] : (r_baddr & ~w_mask) | (w_inc[MA-1:0] & w_mask);
    assign w_next_ok  = (i_bte != 2'd0) || !w_inc[MA];

    assign w_wr       = o_ack & i_we & rstn;
    assign w_waddr    = r_state == S_BURST ? r_baddr : w_idx[MA-1:0];
    assign w_raddr    = r_state == S_BURST ? w_next : w_idx[MA-1:0];
    assign w_start    = (r_state == S_IDLE && w_req && WAIT_STATES == 0) || (r_state == S_WAIT && r_cnt == '0);

    for (genvar k = 0; k < NB; k++) begin : g_lane
        assign w_wdata[8*k +: 8] = i_sel[k] ? i_dat_w[8*k +: 8] : r_mem[w_waddr][8*k +: 8];
    end

    // Write-first: a read-ahead of the word being written sees the new data.
    assign w_rdata = (w_wr && w_waddr == w_raddr) ? w_wdata : r_mem[w_raddr];

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[w_waddr] <= w_wdata;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_baddr <= '0;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_dat_r <= '0;
        end else if (!i_cyc) begin
            r_state <= S_IDLE;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_start) begin
            r_ack   <= w_in_range;
            r_err   <= !w_in_range;
            r_dat_r <= w_in_range ? w_rdata : '0;
            r_baddr <= w_idx[MA-1:0];
            r_state <= (WAIT_STATES == 0 && i_cti == 3'b010 && w_in_range) ? S_BURST : S_RESP;
        end else if (r_state == S_IDLE && w_req) begin
            r_cnt   <= 3'(WAIT_STATES - 1);
            r_state <= S_WAIT;
        end else if (r_state == S_WAIT) begin
            r_cnt <= r_cnt - 3'd1;
        end else if (r_state == S_RESP || o_err || (o_ack && i_cti != 3'b010)) begin
            r_state <= S_IDLE;
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
        end else if (o_ack) begin
            r_baddr <= w_next;
            r_ack   <= w_next_ok;
            r_err   <= !w_next_ok;
            r_dat_r <= w_next_ok ? w_rdata : '0;
        end
    end
endmodule

// File: tb/tb_wb_sram_target.sv
// tb_wb_sram_target: directed bench for wb_sram_target; u0 has no wait states,
// u3 has three, both windowed at 'h1000 and sharing every input except CYC.
module tb_wb_sram_target;
    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] adr, dat_w, dat0, dat3;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic [3:0]  sel;
    logic        stb, we, cyc0, cyc3, ack0, err0, ack3, err3;
    int          passed = 0;
    int          total = 0;
    logic [7:0]  cap_ack, cap_err;
    logic [31:0] cap_dat [8];
    logic [15:0] tr_ack, tr_err;
    logic [31:0] tr_dat [16];
    logic [31:0] rd;
    logic        pre, ack, err;

    always #5 clk = ~clk;

    wb_sram_target #(.BASE_ADDR(32'h1000), .WAIT_STATES(0)) u0 (
        .clk(clk), .rstn(rstn), .i_adr(adr), .i_cti(cti), .i_bte(bte), .i_dat_w(dat_w),
        .i_cyc(cyc0), .i_sel(sel), .i_stb(stb), .i_we(we), .o_dat_r(dat0), .o_ack(ack0), .o_err(err0));

    wb_sram_target #(.BASE_ADDR(32'h1000), .WAIT_STATES(3)) u3 (
        .clk(clk), .rstn(rstn), .i_adr(adr), .i_cti(cti), .i_bte(bte), .i_dat_w(dat_w),
        .i_cyc(cyc3), .i_sel(sel), .i_stb(stb), .i_we(we), .o_dat_r(dat3), .o_ack(ack3), .o_err(err3));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        cyc0 = 1'b0; cyc3 = 1'b0; stb = 1'b0; we = 1'b0;
        cti = 3'b000; bte = 2'b00; sel = 4'hF; adr = '0; dat_w = '0;
    endtask

    // Single classic cycle on u0; captures the cycle before and the cycle after the request edge.
    task automatic classic0(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [3:0] s,
                            output logic p, output logic [31:0] r, output logic k, output logic e);
        adr = a; we = w; dat_w = d; sel = s; cti = 3'b000; cyc0 = 1'b1; stb = 1'b1;
        @(negedge clk); p = ack0;
        tick;
        @(negedge clk); r = dat0; k = ack0; e = err0;
        tick;
        idle;
        tick;
    endtask

    // u0 burst: cycle 0 precedes the first request edge, cycles 1..n are beats, n+1 follows.
    task automatic burst_cap0(input logic [31:0] a, input logic [1:0] b, input int n, input logic term);
        adr = a; we = 1'b0; bte = b; cti = 3'b010; cyc0 = 1'b1; stb = 1'b1;
        for (int k = 0; k <= n + 1; k++) begin
            if (term && k == n) cti = 3'b111;
            @(negedge clk);
            cap_ack[k] = ack0; cap_err[k] = err0; cap_dat[k] = dat0;
            if (k == n + 1) idle;
            tick;
        end
    endtask

    // u3: hold a request for n edges and record ACK/ERR/DAT_R in each cycle.
    task automatic trace3(input logic [31:0] a, input logic w, input logic [31:0] d, input logic [2:0] c, input int n);
        adr = a; we = w; dat_w = d; sel = 4'hF; cti = c; cyc3 = 1'b1; stb = 1'b1;
        tr_ack = '0; tr_err = '0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            tr_ack[k] = ack3; tr_err[k] = err3; tr_dat[k] = dat3;
            tick;
        end
        idle;
        tick;
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        idle;
        cyc0 = 1'b1; cyc3 = 1'b1; stb = 1'b1;
        tick; tick;
        @(negedge clk);
        total++; if ({ack0, err0, ack3, err3} !== 4'b0) $display("FAIL reset_flags: got %b exp 0000", {ack0, err0, ack3, err3}); else passed++;
        total++; if (dat0 !== 32'h0) $display("FAIL reset_dat0: got %h exp 00000000", dat0); else passed++;
        total++; if (dat3 !== 32'h0) $display("FAIL reset_dat3: got %h exp 00000000", dat3); else passed++;
        idle;
        rstn = 1'b1;
        tick;
    endtask

    task automatic test_classic;
        classic0(32'h1004, 1'b1, 32'hDEADBEEF, 4'hF, pre, rd, ack, err);
        total++; if ({pre, ack, err} !== 3'b010) $display("FAIL wr_handshake: got pre/ack/err %b exp 010", {pre, ack, err}); else passed++;
        classic0(32'h1004, 1'b0, 32'h0, 4'hF, pre, rd, ack, err);
        total++; if ({pre, ack, err} !== 3'b010) $display("FAIL rd_handshake: got pre/ack/err %b exp 010", {pre, ack, err}); else passed++;
        total++; if (rd !== 32'hDEADBEEF) $display("FAIL rd_data: got %h exp deadbeef", rd); else passed++;
    endtask

    task automatic test_byte_write;
        classic0(32'h1004, 1'b1, 32'h0000AB00, 4'b0010, pre, rd, ack, err);
        classic0(32'h1007, 1'b0, 32'h0, 4'hF, pre, rd, ack, err);
        total++; if (rd !== 32'hDEADABEF) $display("FAIL byte_write: got %h exp deadabef", rd); else passed++;
    endtask

    task automatic test_burst_incr;
        for (int i = 0; i < 4; i++) classic0(32'h1000 + 32'(4 * i), 1'b1, 32'hC0DE0000 + 32'(i), 4'hF, pre, rd, ack, err);
        burst_cap0(32'h1000, 2'b00, 4, 1'b1);
        total++; if (cap_ack[5:0] !== 6'b011110) $display("FAIL incr_ack: got %b exp 011110", cap_ack[5:0]); else passed++;
        total++; if (cap_err[5:0] !== 6'b0) $display("FAIL incr_err: got %b exp 000000", cap_err[5:0]); else passed++;
        for (int k = 1; k <= 4; k++) begin
            total++; if (cap_dat[k] !== 32'hC0DE0000 + 32'(k - 1)) $display("FAIL incr_dat%0d: got %h exp %h", k, cap_dat[k], 32'hC0DE0000 + 32'(k - 1)); else passed++;
        end
    endtask

    task automatic test_burst_wrap;
        logic [31:0] e [4] = '{32'hC0DE0002, 32'hC0DE0003, 32'hC0DE0000, 32'hC0DE0001};
        burst_cap0(32'h1008, 2'b01, 4, 1'b1);
        total++; if (cap_ack[5:0] !== 6'b011110) $display("FAIL wrap_ack: got %b exp 011110", cap_ack[5:0]); else passed++;
        for (int k = 1; k <= 4; k++) begin
            total++; if (cap_dat[k] !== e[k-1]) $display("FAIL wrap_dat%0d: got %h exp %h", k, cap_dat[k], e[k-1]); else passed++;
        end
    endtask

    task automatic test_err;
        classic0(32'h2000, 1'b0, 32'h0, 4'hF, pre, rd, ack, err);
        total++; if ({ack, err, rd} !== {2'b01, 32'h0}) $display("FAIL err_read: got ack/err %b%b dat %h exp 01 00000000", ack, err, rd); else passed++;
        classic0(32'h2000, 1'b1, 32'hFFFFFFFF, 4'hF, pre, rd, ack, err);
        total++; if ({ack, err} !== 2'b01) $display("FAIL err_write: got ack/err %b exp 01", {ack, err}); else passed++;
        classic0(32'h0FFC, 1'b0, 32'h0, 4'hF, pre, rd, ack, err);
        total++; if ({ack, err} !== 2'b01) $display("FAIL err_below: got ack/err %b exp 01", {ack, err}); else passed++;
        classic0(32'h1000, 1'b0, 32'h0, 4'hF, pre, rd, ack, err);
        total++; if (rd !== 32'hC0DE0000) $display("FAIL err_nowrite: got %h exp c0de0000", rd); else passed++;
    endtask

    task automatic test_overflow;
        classic0(32'h1FF8, 1'b1, 32'hAAAA0001, 4'hF, pre, rd, ack, err);
        classic0(32'h1FFC, 1'b1, 32'hAAAA0002, 4'hF, pre, rd, ack, err);
        burst_cap0(32'h1FF8, 2'b00, 3, 1'b0);
        total++; if (cap_ack[4:0] !== 5'b00110) $display("FAIL ovf_ack: got %b exp 00110", cap_ack[4:0]); else passed++;
        total++; if (cap_err[4:0] !== 5'b01000) $display("FAIL ovf_err: got %b exp 01000", cap_err[4:0]); else passed++;
        total++; if ({cap_dat[1], cap_dat[2], cap_dat[3]} !== {32'hAAAA0001, 32'hAAAA0002, 32'h0}) $display("FAIL ovf_dat: got %h %h %h exp aaaa0001 aaaa0002 00000000", cap_dat[1], cap_dat[2], cap_dat[3]); else passed++;
        classic0(32'h1FFC, 1'b0, 32'h0, 4'hF, pre, rd, ack, err);
        total++; if ({ack, rd} !== {1'b1, 32'hAAAA0002}) $display("FAIL ovf_idle: got ack %b dat %h exp 1 aaaa0002", ack, rd); else passed++;
    endtask

    task automatic test_stb_gap;
        logic       s_t [7] = '{1, 1, 1, 0, 0, 1, 1};
        logic [6:0] a_obs;
        logic [31:0] d_obs [7];
        adr = 32'h1000; we = 1'b0; bte = 2'b00; cyc0 = 1'b1;
        for (int k = 0; k < 7; k++) begin
            stb = s_t[k];
            cti = k >= 5 ? 3'b111 : 3'b010;
            @(negedge clk);
            a_obs[k] = ack0; d_obs[k] = dat0;
            if (k == 6) idle;
            tick;
        end
        total++; if (a_obs !== 7'b0100110) $display("FAIL gap_ack: got %b exp 0100110", a_obs); else passed++;
        total++; if ({d_obs[1], d_obs[2]} !== {32'hC0DE0000, 32'hC0DE0001}) $display("FAIL gap_pre: got %h %h exp c0de0000 c0de0001", d_obs[1], d_obs[2]); else passed++;
        total++; if ({d_obs[3], d_obs[5]} !== {32'hC0DE0002, 32'hC0DE0002}) $display("FAIL gap_resume: got %h %h exp c0de0002 c0de0002", d_obs[3], d_obs[5]); else passed++;
    endtask

    task automatic test_reset_mid_burst;
        adr = 32'h1000; we = 1'b1; dat_w = 32'hFFFFFFFF; sel = 4'hF; bte = 2'b00; cti = 3'b010; cyc0 = 1'b1; stb = 1'b1;
        tick;
        rstn = 1'b0;
        tick;
        @(negedge clk);
        total++; if ({ack0, err0, dat0} !== {2'b00, 32'h0}) $display("FAIL rst_burst: got ack/err %b%b dat %h exp 00 00000000", ack0, err0, dat0); else passed++;
        idle;
        rstn = 1'b1;
        tick;
        classic0(32'h1000, 1'b0, 32'h0, 4'hF, pre, rd, ack, err);
        total++; if (rd !== 32'hC0DE0000) $display("FAIL rst_nowrite: got %h exp c0de0000", rd); else passed++;
    endtask

    task automatic test_wait_states;
        trace3(32'h1010, 1'b1, 32'h12345678, 3'b000, 5);
        total++; if (tr_ack[4:0] !== 5'b10000) $display("FAIL ws_wr_ack: got %b exp 10000", tr_ack[4:0]); else passed++;
        trace3(32'h1010, 1'b0, 32'h0, 3'b000, 6);
        total++; if (tr_ack[5:0] !== 6'b010000) $display("FAIL ws_rd_ack: got %b exp 010000", tr_ack[5:0]); else passed++;
        total++; if (tr_dat[4] !== 32'h12345678) $display("FAIL ws_rd_dat: got %h exp 12345678", tr_dat[4]); else passed++;
        total++; if (tr_err !== 16'h0) $display("FAIL ws_rd_err: got %h exp 0000", tr_err); else passed++;
    endtask

    task automatic test_ws_burst;
        trace3(32'h1010, 1'b0, 32'h0, 3'b010, 11);
        total++; if (tr_ack[10:0] !== 11'b01000010000) $display("FAIL ws_burst_ack: got %b exp 01000010000", tr_ack[10:0]); else passed++;
    endtask

    task automatic test_cyc_drop_wait;
        trace3(32'h1014, 1'b1, 32'h11112222, 3'b000, 5);
        trace3(32'h1014, 1'b1, 32'h55AA55AA, 3'b000, 2);
        total++; if (tr_ack[1:0] !== 2'b00) $display("FAIL drop_ack: got %b exp 00", tr_ack[1:0]); else passed++;
        tick; tick;
        trace3(32'h1014, 1'b0, 32'h0, 3'b000, 6);
        total++; if (tr_ack[5:0] !== 6'b010000) $display("FAIL drop_relat: got %b exp 010000", tr_ack[5:0]); else passed++;
        total++; if (tr_dat[4] !== 32'h11112222) $display("FAIL drop_nowrite: got %h exp 11112222", tr_dat[4]); else passed++;
    endtask

    initial begin
        test_reset;
        test_classic;
        test_byte_write;
        test_burst_incr;
        test_burst_wrap;
        test_err;
        test_overflow;
        test_stb_gap;
        test_reset_mid_burst;
        test_wait_states;
        test_ws_burst;
        test_cyc_drop_wait;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
